i2s_tdm_transmitter: RTL and testbench

I2S_TDM_TRANSMITTER -- requirements
Module: i2s_tdm_transmitter

---
 rtl/i2s_tdm_transmitter.sv | 174 +++++++++++++++++
 tb/tb_i2s_tdm_transmitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_tdm_transmitter
//
// Serialises TDM audio frames from a circular sample RAM onto an I2S /
// left-justified link. One clk_x4_i period is a quarter of a bit clock; the
// block walks a {frame, bit} address through the RAM and replays the last
// frame when the producer falls behind, falling back to silence after
// MISS_LIMIT consecutive misses.
//
// Ports
//   clk_x4_i              : single clock, 4x bit clock
//   rst_ni                : asynchronous active-low reset
//   resync_req_i          : 1 enables output, 0 forces Idle
//   fmt_i                 : 0 = left-justified, 1 = I2S (one-bit lag); latched in Idle
//   last_good_frame_idx_i : newest complete frame in RAM
//   ram_data_i            : RAM read data, one clk_x4_i after ram_read_addr_o
//   ram_read_addr_o       : {frame index, bit index} for the next bit tick
//   i2s_running_o         : high whenever state is not Idle
//   i2s_bclk_o            : bit clock (constant 1 in Idle)
//   i2s_fsync_o           : frame sync, low in first half of frame
//   i2s_data_o            : registered serial data
//   underrun_cnt_o        : saturating missed-frame count since last entry to Data
// -----------------------------------------------------------------------------
module i2s_tdm_transmitter #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int CHANNELS      = 8,
    parameter int MISS_LIMIT    = 5,
    localparam int FB           = $clog2(CHANNELS * 32)
) (
    input  logic                        clk_x4_i,
    input  logic                        rst_ni,
    input  logic                        resync_req_i,
    input  logic                        fmt_i,
    input  logic [CIRC_BUF_BITS-1:0]    last_good_frame_idx_i,
    input  logic                        ram_data_i,
    output logic [CIRC_BUF_BITS+FB-1:0] ram_read_addr_o,
    output logic                        i2s_running_o,
    output logic                        i2s_bclk_o,
    output logic                        i2s_fsync_o,
    output logic                        i2s_data_o,
    output logic [7:0]                  underrun_cnt_o
);

    typedef enum logic [1:0] {IDLE, ZEROS, DATA} state_e;

    state_e                   state_q, state_nxt;
    logic [1:0]               phase_q;
    logic [FB-1:0]            bit_idx_q;
    logic [CIRC_BUF_BITS-1:0] read_frame_q, frame_nxt;
    logic [7:0]               misses_q, misses_nxt, misses_inc;
    logic [7:0]               underrun_q, underrun_nxt, underrun_inc;
    logic                     fmt_q;
    logic                     sample_q, sample_d_q;
    logic                     data_q, fsync_q;

    logic tick, frame_end, new_frame;

    assign tick         = (phase_q == 2'd3);
    assign frame_end    = &bit_idx_q;
    assign new_frame    = (last_good_frame_idx_i != read_frame_q);
    assign misses_inc   = misses_q + 8'd1;
    assign underrun_inc = (underrun_q == 8'hFF) ? underrun_q : underrun_q + 8'd1;

    // State register plus the counters that move with it on each bit tick.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            phase_q      <= 2'd0;
            bit_idx_q    <= '0;
            read_frame_q <= '0;
            misses_q     <= 8'd0;
            underrun_q   <= 8'd0;
            fmt_q        <= 1'b0;
            sample_q     <= 1'b0;
            sample_d_q   <= 1'b0;
        end else begin
            phase_q <= phase_q + 2'd1;
            // Format is only allowed to change while the link is stopped.
            if (state_q == IDLE) begin
                fmt_q <= fmt_i;
            end
            if (tick) begin
                bit_idx_q    <= bit_idx_q + FB'(1);
                state_q      <= state_nxt;
                read_frame_q <= frame_nxt;
                misses_q     <= misses_nxt;
                underrun_q   <= underrun_nxt;
                // Gating at capture makes Zeros silent and lets the I2S lag
                // stage carry the last real bit into the next frame.
                sample_q     <= (state_nxt == DATA) & ram_data_i;
                sample_d_q   <= sample_q;
            end
        end
    end

    // Next-state logic, evaluated as if the current cycle were a bit tick.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_nxt    = state_q;
        frame_nxt    = read_frame_q;
        misses_nxt   = misses_q;
        underrun_nxt = underrun_q;
        if (!resync_req_i) begin
            state_nxt = IDLE;
        end else if (frame_end) begin
            unique case (state_q)
                IDLE, ZEROS: begin
                    if (new_frame) begin
                        state_nxt    = DATA;
                        frame_nxt    = last_good_frame_idx_i;
                        misses_nxt   = 8'd0;
                        underrun_nxt = 8'd0;
                    end else begin
                        state_nxt = ZEROS;
                        // Idle has no output to miss; only Zeros counts.
                        if (state_q == ZEROS) begin
                            underrun_nxt = underrun_inc;
                        end
                    end
                end
                DATA: begin
                    if (new_frame) begin
                        frame_nxt  = read_frame_q + CIRC_BUF_BITS'(1);
                        misses_nxt = 8'd0;
                    end else begin
                        misses_nxt   = misses_inc;
                        underrun_nxt = underrun_inc;
                        if (misses_inc >= 8'(MISS_LIMIT)) begin
                            state_nxt = ZEROS;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Serial outputs change on falling bclk (phase 1->2); entering Idle
    // clears them at the tick itself so Idle never shows stale data.
    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= 1'b0;
            fsync_q <= 1'b0;
        end else if (tick && state_nxt == IDLE) begin
            data_q  <= 1'b0;
            fsync_q <= 1'b0;
        end else if (phase_q == 2'd1) begin
            if (state_q == IDLE) begin
                data_q  <= 1'b0;
                fsync_q <= 1'b0;
            end else begin
                data_q  <= fmt_q ? sample_d_q : sample_q;
                // Second half of the frame is exactly the bit-index MSB.
                fsync_q <= bit_idx_q[FB-1];
            end
        end
    end

    // Output decode.
    always_comb begin
        i2s_running_o   = (state_q != IDLE);
        i2s_bclk_o      = i2s_running_o ? ~phase_q[1] : 1'b1;
        // Frame field follows the boundary decision so the first bit of a
        // new frame is already being fetched during the last bit period.
        ram_read_addr_o = {frame_nxt, bit_idx_q + FB'(1)};
    end

    assign i2s_fsync_o    = fsync_q;
    assign i2s_data_o     = data_q;
    assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_tdm_transmitter
//
// Directed bench for i2s_tdm_transmitter with CHANNELS=2 (64-bit frames,
// 256 clk_x4_i cycles per frame). A behavioural RAM returns one bit of a
// per-frame 64-bit pattern one cycle after the address. Timing is tracked by
// a cycle counter cleared by reset: after posedge k the DUT is in bit period
// (k/4)%64 of frame k/256, and serial outputs update at posedge 256n+4b+2.
// -----------------------------------------------------------------------------
module tb_i2s_tdm_transmitter;

    localparam int CBB   = 3;
    localparam int CH    = 2;
    localparam int ML    = 5;
    localparam int AW    = 9;
    localparam int FRAME = 256;

    logic           clk_x4_i = 1'b0;
    logic           rst_ni   = 1'b0;
    logic           resync   = 1'b0;
    logic           fmt      = 1'b0;
    logic [CBB-1:0] lg       = '0;
    logic           ram_data = 1'b0;
    logic [AW-1:0]  addr;
    logic           running, bclk, fsync, data;
    logic [7:0]     underrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk_x4_i = ~clk_x4_i;

    i2s_tdm_transmitter #(
        .CIRC_BUF_BITS(CBB),
        .CHANNELS     (CH),
        .MISS_LIMIT   (ML)
    ) dut (
        .clk_x4_i             (clk_x4_i),
        .rst_ni               (rst_ni),
        .resync_req_i         (resync),
        .fmt_i                (fmt),
        .last_good_frame_idx_i(lg),
        .ram_data_i           (ram_data),
        .ram_read_addr_o      (addr),
        .i2s_running_o        (running),
        .i2s_bclk_o           (bclk),
        .i2s_fsync_o          (fsync),
        .i2s_data_o           (data),
        .underrun_cnt_o       (underrun)
    );

    // Serial bit i of frame f; bit 0 is the MSB of slot 0.
    function automatic logic [63:0] pat(input logic [2:0] f);
        logic [7:0] b8;
        b8 = 8'h11 * ({5'd0, f} + 8'd1);
        return 64'hC123_4567_89AB_CDEE ^ {8{b8}};
    endfunction

    function automatic logic pat_bit(input logic [2:0] f, input logic [5:0] i);
        logic [63:0] w;
        w = pat(f);
        return w[6'd63 - i];
    endfunction

    always @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clk_x4_i) ram_data <= pat_bit(addr[8:6], addr[5:0]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_to(input int k);
        while (cyc < k) @(negedge clk_x4_i);
    endtask

    typedef struct {
        int       n;          // frame number to check
        logic [2:0] lg;       // last_good applied before that frame's boundary
        logic       data_on;  // 1 = Data, 0 = Zeros
        logic [2:0] frame;    // expected read frame field
        logic [7:0] under;    // expected underrun count
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  byte_v;
        logic [63:0] w;
        int          hi_cnt;

        tbl[0] = '{3,  3'd2, 1'b1, 3'd2, 8'd2};
        tbl[1] = '{4,  3'd2, 1'b1, 3'd2, 8'd3};
        tbl[2] = '{5,  3'd2, 1'b1, 3'd2, 8'd4};
        tbl[3] = '{6,  3'd2, 1'b0, 3'd2, 8'd5};
        tbl[4] = '{7,  3'd2, 1'b0, 3'd2, 8'd6};
        tbl[5] = '{8,  3'd7, 1'b1, 3'd7, 8'd0};
        tbl[6] = '{9,  3'd0, 1'b1, 3'd0, 8'd0};
        tbl[7] = '{10, 3'd1, 1'b1, 3'd1, 8'd0};
        tbl[8] = '{11, 3'd1, 1'b1, 3'd1, 8'd1};

        // Reset values.
        resync = 1'b1;
        fmt    = 1'b0;
        lg     = 3'd2;
        repeat (3) @(negedge clk_x4_i);
        check("rst_running", running, 0);
        check("rst_bclk", bclk, 1);
        check("rst_fsync", fsync, 0);
        check("rst_data", data, 0);
        check("rst_underrun", underrun, 0);
        check("rst_addr", addr, 9'd1);
        rst_ni = 1'b1;

        // Frame 0 stays in Idle.
        run_to(15);
        check("idle_running", running, 0);
        check("idle_bclk", bclk, 1);
        check("idle_data", data, 0);

        // First boundary: Idle -> Data on frame 2, left-justified.
        run_to(FRAME + 1);
        check("f1_bclk_hi", bclk, 1);
        run_to(FRAME + 3);
        check("f1_bclk_lo", bclk, 0);
        check("f1_running", running, 1);
        check("f1_addr", addr, {3'd2, 6'd1});
        check("f1_data_b0", data, pat_bit(2, 0));
        check("f1_underrun", underrun, 0);
        run_to(FRAME + 4 * 63 + 3);
        check("f1_fsync_b63", fsync, 1);
        run_to(2 * FRAME + 1);
        check("f2_fsync_before_fall", fsync, 1);
        check("f2_data_before_fall", data, pat_bit(2, 63));
        run_to(2 * FRAME + 2);
        check("f2_fsync_fall", fsync, 0);
        check("f2_msb_at_fall", data, pat_bit(2, 0));
        check("f2_underrun", underrun, 1);

        // Frame-by-frame table: replay, fall back to Zeros, recovery, wrap.
        for (int i = 0; i < 9; i++) begin
            run_to(FRAME * (tbl[i].n - 1) + 100);
            lg     = tbl[i].lg;
            byte_v = 8'd0;
            for (int b = 0; b < 8; b++) begin
                run_to(FRAME * tbl[i].n + 4 * b + 3);
                byte_v = {byte_v[6:0], data};
            end
            w = pat(tbl[i].frame);
            check($sformatf("tbl%0d_running", tbl[i].n), running, 1);
            check($sformatf("tbl%0d_underrun", tbl[i].n), underrun, tbl[i].under);
            check($sformatf("tbl%0d_addr", tbl[i].n), addr, {tbl[i].frame, 6'd8});
            check($sformatf("tbl%0d_byte", tbl[i].n), byte_v,
                  tbl[i].data_on ? w[63:56] : 8'd0);
        end

        // Drop resync mid-frame: Idle at the next bit tick.
        run_to(12 * FRAME + 41);
        resync = 1'b0;
        run_to(12 * FRAME + 43);
        check("drop_before_tick", running, 1);
        run_to(12 * FRAME + 44);
        check("drop_running", running, 0);
        check("drop_bclk", bclk, 1);
        check("drop_data", data, 0);
        check("drop_fsync", fsync, 0);

        // Re-assert with I2S format selected while Idle.
        fmt = 1'b1;
        run_to(12 * FRAME + 80);
        resync = 1'b1;
        lg     = 3'd2;
        run_to(12 * FRAME + 160);
        check("reassert_wait", running, 0);

        // Frame 13: I2S, every bit lags one bclk, fsync 50% duty.
        hi_cnt = 0;
        for (int b = 0; b < 64; b++) begin
            run_to(13 * FRAME + 4 * b + 3);
            check($sformatf("i2s_data_b%0d", b), data,
                  (b == 0) ? 1'b0 : pat_bit(2, 6'(b - 1)));
            check($sformatf("i2s_fsync_b%0d", b), fsync, (b >= 32));
            if (fsync) hi_cnt++;
        end
        check("i2s_fsync_high_count", hi_cnt, 32);
        check("i2s_underrun", underrun, 0);

        // Format change outside Idle has no effect; last bit crosses frames.
        fmt = 1'b0;
        run_to(14 * FRAME + 3);
        check("f14_lag_b0", data, pat_bit(2, 63));
        run_to(14 * FRAME + 4 * 5 + 3);
        check("f14_fmt_locked", data, pat_bit(2, 4));
        check("f14_underrun", underrun, 1);

        // Reset mid-slot: outputs return to reset values immediately.
        run_to(15 * FRAME + 4 * 40 + 3);
        check("pre_rst_running", running, 1);
        check("pre_rst_fsync", fsync, 1);
        check("pre_rst_underrun", underrun, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_running", running, 0);
        check("midrst_bclk", bclk, 1);
        check("midrst_fsync", fsync, 0);
        check("midrst_data", data, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_addr", addr, 9'd1);

        // Resume only through Idle.
        repeat (2) @(negedge clk_x4_i);
        rst_ni = 1'b1;
        run_to(4 * 10 + 3);
        check("resume_idle", running, 0);
        run_to(FRAME + 3);
        check("resume_running", running, 1);
        check("resume_addr", addr, {3'd2, 6'd1});
        check("resume_data", data, pat_bit(2, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
